// File: rtl/switch_edge_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : switch_edge_irq_ctrl
// Brief   : Debounced switch input port with edge capture and a level
//           interrupt. Registers are reached over an Avalon-MM slave.
// Rev     : 1.0  initial release
// ============================================================================
module switch_edge_irq_ctrl #(
   parameter int          WIDTH        = 8,
   parameter int          DEBOUNCE_CNT = 3,
   parameter logic [15:0] DIV_RESET    = 16'd1000,
   parameter int          EDGE_TYPE    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [1:0] c_ADDR_DATA = 2'd0;
   localparam logic [1:0] c_ADDR_MASK = 2'd1;
   localparam logic [1:0] c_ADDR_EDGE = 2'd2;
   localparam logic [1:0] c_ADDR_DIV  = 2'd3;

   localparam logic [0:0] c_ST_INIT = 1'b0;
   localparam logic [0:0] c_ST_RUN  = 1'b1;

   localparam logic [3:0] c_DEB_MAX = 4'(DEBOUNCE_CNT);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [15:0]      r_presc;
   logic [15:0]      r_div;
   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_deb;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic [3:0]       r_cnt [WIDTH];

   logic             w_wr;
   logic             w_wr_mask;
   logic             w_wr_edge;
   logic             w_wr_div;
   logic [15:0]      w_div_last;
   logic             w_tick;
   logic [WIDTH-1:0] w_deb_next;
   logic [3:0]       w_cnt_next [WIDTH];
   logic [WIDTH-1:0] w_evt;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_cap_next;
   logic [WIDTH-1:0] w_mask_next;
   logic [31:0]      w_rd;
   logic             w_unused_wdata;

   assign w_wr      = chipselect & ~write_n;
   assign w_wr_mask = w_wr && (address == c_ADDR_MASK);
   assign w_wr_edge = w_wr && (address == c_ADDR_EDGE);
   assign w_wr_div  = w_wr && (address == c_ADDR_DIV);

   assign w_unused_wdata = ^writedata[31:16];

   // A divisor of zero wraps at 0, i.e. behaves exactly like a divisor of one.
   assign w_div_last = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
   assign w_tick     = (r_presc == w_div_last);

   always_comb begin
      w_deb_next = r_deb;
      w_evt      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_next[i] = r_cnt[i];
      end
      if (w_tick) begin
         if (r_state == c_ST_INIT) begin
            w_deb_next = r_sync2;
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               if (r_sync2[i] != r_deb[i]) begin
                  if ((r_cnt[i] + 4'd1) == c_DEB_MAX) begin
                     w_deb_next[i] = r_sync2[i];
                     w_cnt_next[i] = 4'd0;
                     if (EDGE_TYPE == 0) begin
                        w_evt[i] = r_sync2[i];
                     end else if (EDGE_TYPE == 1) begin
                        w_evt[i] = ~r_sync2[i];
                     end else begin
                        w_evt[i] = 1'b1;
                     end
                  end else begin
                     w_cnt_next[i] = r_cnt[i] + 4'd1;
                  end
               end else begin
                  w_cnt_next[i] = 4'd0;
               end
            end
         end
      end
   end

   // A fresh event wins over a simultaneous write-1-to-clear.
   assign w_clr       = w_wr_edge ? writedata[WIDTH-1:0] : '0;
   assign w_cap_next  = (r_cap & ~w_clr) | w_evt;
   assign w_mask_next = w_wr_mask ? writedata[WIDTH-1:0] : r_mask;

   always_comb begin
      w_rd = '0;
      case (address)
         c_ADDR_DATA: w_rd[WIDTH-1:0] = r_deb;
         c_ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
         c_ADDR_EDGE: w_rd[WIDTH-1:0] = r_cap;
         c_ADDR_DIV:  w_rd[15:0]      = r_div;
         default:     w_rd            = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_presc  <= 16'd0;
         r_div    <= DIV_RESET;
         r_state  <= c_ST_INIT;
         r_deb    <= '0;
         r_mask   <= '0;
         r_cap    <= '0;
         readdata <= 32'd0;
         irq      <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= 4'd0;
         end
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
         if (w_wr_div || w_tick) begin
            r_presc <= 16'd0;
         end else begin
            r_presc <= r_presc + 16'd1;
         end
         if (w_wr_div) begin
            r_div <= writedata[15:0];
         end
         if (w_tick) begin
            r_state <= c_ST_RUN;
         end
         r_deb    <= w_deb_next;
         r_mask   <= w_mask_next;
         r_cap    <= w_cap_next;
         readdata <= w_rd;
         irq      <= |(w_cap_next & w_mask_next);
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_next[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_switch_edge_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_edge_irq_ctrl
// Brief   : Directed self-checking bench for switch_edge_irq_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_switch_edge_irq_ctrl;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic        irq;

   int          n_checks;
   int          n_errors;
   logic [31:0] rd;

   switch_edge_irq_ctrl #(
      .WIDTH        (8),
      .DEBOUNCE_CNT (3),
      .DIV_RESET    (16'd1000),
      .EDGE_TYPE    (0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a;
      step(1);
      d = readdata;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      in_port    = 8'h05;

      // Reset state, and a bus write during reset must be overridden
      step(3);
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      bus_write(2'd1, 32'h0000_00FF);
      reset = 1'b0;

      // First tick in INIT loads the level directly, no capture
      bus_write(2'd3, 32'd4);
      step(10);
      bus_read(2'd0, rd);  check("init_data", rd, 32'h05);
      bus_read(2'd2, rd);  check("init_edge", rd, 32'h00);
      bus_read(2'd1, rd);  check("mask_rst_override", rd, 32'h00);
      check("init_irq", {31'd0, irq}, 32'd0);

      bus_write(2'd1, 32'hFFFF_FF01);
      bus_read(2'd1, rd);  check("mask_high_ignored", rd, 32'h01);
      bus_write(2'd0, 32'hFF);
      bus_read(2'd0, rd);  check("data_write_ignored", rd, 32'h05);

      // Falling edge is debounced but not captured with rising-edge type
      in_port = 8'h04;
      step(30);
      bus_read(2'd0, rd);  check("fall_data", rd, 32'h04);
      bus_read(2'd2, rd);  check("fall_no_edge", rd, 32'h00);
      check("fall_irq", {31'd0, irq}, 32'd0);

      // Rising bit0 with prescaler phase pinned by the DIV write at edge W
      in_port = 8'h05;
      bus_write(2'd3, 32'd4);
      address = 2'd0;
      step(11);
      check("rise_irq_w11", {31'd0, irq}, 32'd0);
      step(1);
      check("rise_irq_w12", {31'd0, irq}, 32'd1);
      check("rise_data_w12", readdata, 32'h04);
      step(1);
      check("rise_data_w13", readdata, 32'h05);
      bus_read(2'd2, rd);  check("rise_edge", rd, 32'h01);

      bus_write(2'd2, 32'h01);
      check("clr_irq", {31'd0, irq}, 32'd0);
      bus_read(2'd2, rd);  check("clr_edge", rd, 32'h00);

      // Two-tick low glitch on bit0 must not be accepted
      in_port = 8'h04;
      bus_write(2'd3, 32'd4);
      address = 2'd0;
      step(8);
      in_port = 8'h05;
      step(20);
      bus_read(2'd0, rd);  check("glitch_data", rd, 32'h05);
      bus_read(2'd2, rd);  check("glitch_edge", rd, 32'h00);
      check("glitch_irq", {31'd0, irq}, 32'd0);

      // DIV = 0: tick every cycle
      bus_write(2'd3, 32'd0);
      bus_read(2'd3, rd);  check("div0_read", rd, 32'h0);
      address = 2'd0;
      in_port = 8'h04;
      step(1);
      step(4);
      check("div0_fall_f4", readdata, 32'h05);
      step(1);
      check("div0_fall_f5", readdata, 32'h04);

      in_port = 8'h05;
      step(1);
      step(3);
      check("div0_rise_r3_irq", {31'd0, irq}, 32'd0);
      step(1);
      check("div0_rise_r4_irq", {31'd0, irq}, 32'd1);
      bus_read(2'd2, rd);  check("div0_rise_edge", rd, 32'h01);
      bus_write(2'd2, 32'h01);
      check("div0_clr_irq", {31'd0, irq}, 32'd0);

      // Event and write-1-to-clear on the same edge: bit stays set
      in_port = 8'h04;
      step(6);
      in_port = 8'h05;
      step(1);
      step(3);
      bus_write(2'd2, 32'h01);
      check("collide_irq", {31'd0, irq}, 32'd1);
      bus_read(2'd2, rd);  check("collide_edge", rd, 32'h01);

      // Mask change drives irq; mask write leaves capture alone
      bus_write(2'd1, 32'h00);
      check("unmask_irq", {31'd0, irq}, 32'd0);
      bus_write(2'd2, 32'h01);
      in_port = 8'h85;
      step(8);
      check("b7_masked_irq", {31'd0, irq}, 32'd0);
      bus_read(2'd2, rd);  check("b7_edge", rd, 32'h80);
      bus_write(2'd1, 32'h80);
      check("b7_mask_irq", {31'd0, irq}, 32'd1);
      bus_read(2'd2, rd);  check("b7_edge_kept", rd, 32'h80);

      reset = 1'b1;
      step(2);
      check("rst2_irq", {31'd0, irq}, 32'd0);
      check("rst2_readdata", readdata, 32'd0);
      reset = 1'b0;
      bus_read(2'd1, rd);  check("rst2_mask", rd, 32'h00);
      bus_read(2'd3, rd);  check("rst2_div", rd, 32'h3E8);
      bus_read(2'd2, rd);  check("rst2_edge", rd, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
